// File: rtl/register_bank_pkg.sv
// Shared constants for the register bank: default geometry and register count.
package register_bank_pkg;

  localparam int unsigned DEFAULT_ADDRESS_SIZE  = 5;
  localparam int unsigned DEFAULT_REGISTER_SIZE = 8;
  localparam int unsigned NUM_REGS              = 1 << DEFAULT_ADDRESS_SIZE;

  // Register count for a given address width.
  function automatic int unsigned num_regs(input int unsigned address_size);
    return 1 << address_size;
  endfunction

endpackage

// File: rtl/register_bank_read_port.sv
// One combinational read port of the register bank.
// Optional write-through forwarding is enabled by defining REG_BYPASS_EN.
module register_bank_read_port
  import register_bank_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE  = DEFAULT_ADDRESS_SIZE,
  parameter int unsigned REGISTER_SIZE = DEFAULT_REGISTER_SIZE
) (
  input  logic [(2**ADDRESS_SIZE)-1:0][REGISTER_SIZE-1:0] regs,
  input  logic [ADDRESS_SIZE-1:0]                         rd_addr,
  input  logic                                            bypass_en,
  input  logic [ADDRESS_SIZE-1:0]                         wr_addr,
  input  logic [REGISTER_SIZE-1:0]                        wr_data,
  output logic [REGISTER_SIZE-1:0]                        rd_data_c
);

`ifdef REG_BYPASS_EN
  // Read mux with forwarding of the in-flight write to the same address.
  always_comb begin
    rd_data_c = regs[rd_addr];
    if (bypass_en && (rd_addr == wr_addr)) begin
      rd_data_c = wr_data;
    end
  end
`else
  // Forwarding inputs are intentionally ignored in the plain build.
  logic unused_bypass;
  assign unused_bypass = ^{bypass_en, wr_addr, wr_data};

  // Plain read mux: stored contents only.
  always_comb begin
    rd_data_c = regs[rd_addr];
  end
`endif

endmodule

// File: rtl/register_bank.sv
// General-purpose register file: 2^ADDRESS_SIZE x REGISTER_SIZE storage,
// one synchronous write port, two combinational read ports.
// Optional macro: REG_BYPASS_EN (write-through forwarding on both read ports).
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE  = DEFAULT_ADDRESS_SIZE,
  parameter int unsigned REGISTER_SIZE = DEFAULT_REGISTER_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     write,
  input  logic [ADDRESS_SIZE-1:0]  addr_in,
  input  logic [ADDRESS_SIZE-1:0]  addr_out1,
  input  logic [ADDRESS_SIZE-1:0]  addr_out2,
  output logic [REGISTER_SIZE-1:0] data_out1,
  output logic [REGISTER_SIZE-1:0] data_out2
);

  localparam int unsigned NREGS = num_regs(ADDRESS_SIZE);

  logic [NREGS-1:0][REGISTER_SIZE-1:0] regs;
  logic                                bypass_en;

  // Storage: asynchronous clear, write on rising edge when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '0;
    end else if (write) begin
      regs[addr_in] <= data_in;
    end
  end

  // A write is only forwardable while the bank is out of reset.
  assign bypass_en = write & reset;

  register_bank_read_port #(
    .ADDRESS_SIZE  (ADDRESS_SIZE),
    .REGISTER_SIZE (REGISTER_SIZE)
  ) u_read_port1 (
    .regs      (regs),
    .rd_addr   (addr_out1),
    .bypass_en (bypass_en),
    .wr_addr   (addr_in),
    .wr_data   (data_in),
    .rd_data_c (data_out1)
  );

  register_bank_read_port #(
    .ADDRESS_SIZE  (ADDRESS_SIZE),
    .REGISTER_SIZE (REGISTER_SIZE)
  ) u_read_port2 (
    .regs      (regs),
    .rd_addr   (addr_out2),
    .bypass_en (bypass_en),
    .wr_addr   (addr_in),
    .wr_data   (data_in),
    .rd_data_c (data_out2)
  );

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed table, corner sequences,
// and randomized traffic against an array-based reference model.
module tb_register_bank;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 1 << AW;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          write;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] addr_out1;
  logic [AW-1:0] addr_out2;
  logic [DW-1:0] data_out1;
  logic [DW-1:0] data_out2;

  int total;
  int bad;

  logic [DW-1:0] mem [NR];

  register_bank #(.ADDRESS_SIZE(AW), .REGISTER_SIZE(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .write     (write),
    .addr_in   (addr_in),
    .addr_out1 (addr_out1),
    .addr_out2 (addr_out2),
    .data_out1 (data_out1),
    .data_out2 (data_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] ain;
    logic [DW-1:0] din;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected read value from the model, including forwarding when enabled.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (!reset) return '0;
`ifdef REG_BYPASS_EN
    if (write && (a == addr_in)) return data_in;
`endif
    return mem[a];
  endfunction

  // Advance one rising edge, apply it to the model, settle.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < int'(NR); i++) mem[i] = '0;
    end else if (write) begin
      mem[addr_in] = data_in;
    end
    #1;
  endtask

  vec_t vecs [7];

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < int'(NR); i++) mem[i] = '0;

    // Expected values reflect register k holding k-1 after the sequential fill.
    vecs[0] = '{1'b1, 5'd0,  8'h5C, 5'd0,  5'd0,  8'h5C, 8'h5C};
    vecs[1] = '{1'b1, 5'd7,  8'h11, 5'd7,  5'd0,  8'h11, 8'h5C};
    vecs[2] = '{1'b1, 5'd9,  8'h22, 5'd7,  5'd9,  8'h11, 8'h22};
    vecs[3] = '{1'b0, 5'd0,  8'h00, 5'd9,  5'd9,  8'h22, 8'h22};
    vecs[4] = '{1'b0, 5'd4,  8'hFF, 5'd4,  5'd3,  8'h03, 8'h02};
    vecs[5] = '{1'b0, 5'd4,  8'hFF, 5'd4,  5'd4,  8'h03, 8'h03};
    vecs[6] = '{1'b1, 5'd31, 8'hE7, 5'd31, 5'd30, 8'hE7, 8'h1D};

    // Reset held: a write edge must be ignored and outputs read zero.
    reset = 1'b0; write = 1'b1; addr_in = 5'd3; data_in = 8'hAA;
    addr_out1 = 5'd3; addr_out2 = 5'd0;
    #2;
    check("reset_out1_during", data_out1, 8'h00);
    tick();
    check("reset_out1_after_edge", data_out1, 8'h00);
    check("reset_out2_after_edge", data_out2, 8'h00);
    #2 reset = 1'b1; write = 1'b0;
    #1;
    check("reset_write_ignored", data_out1, 8'h00);

    // Sequential fill: data i into register i+1, port 2 lagging by one.
    for (int i = 0; i <= 30; i++) begin
      write = 1'b1; addr_in = AW'(i + 1); data_in = DW'(i);
      addr_out1 = AW'(i + 1); addr_out2 = AW'(i);
      tick();
      check("fill_port1", data_out1, DW'(i));
      check("fill_port2", data_out2, (i == 0) ? 8'h00 : DW'(i - 1));
    end
    write = 1'b0;

    // Directed vectors: expectations after the edge.
    for (int v = 0; v < 7; v++) begin
      write = vecs[v].wr; addr_in = vecs[v].ain; data_in = vecs[v].din;
      addr_out1 = vecs[v].a1; addr_out2 = vecs[v].a2;
      tick();
      check($sformatf("vec%0d_out1", v), data_out1, vecs[v].exp1);
      check($sformatf("vec%0d_out2", v), data_out2, vecs[v].exp2);
    end
    write = 1'b0;

    // Read-during-write on register 12 (holds 8'h0B from the fill).
    addr_in = 5'd12; addr_out1 = 5'd12; addr_out2 = 5'd12; data_in = 8'h3C; write = 1'b1;
    #1;
`ifdef REG_BYPASS_EN
    check("rdw_before_edge", data_out1, 8'h3C);
`else
    check("rdw_before_edge", data_out1, 8'h0B);
`endif
    tick();
    write = 1'b0;
    #1;
    check("rdw_after_edge", data_out1, 8'h3C);
    check("rdw_after_edge_p2", data_out2, 8'h3C);

    // Zero-latency address change.
    addr_out1 = 5'd20;
    #1;
    check("addr_change", data_out1, 8'h13);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      write     = 1'($urandom_range(0, 1));
      addr_in   = AW'($urandom_range(0, NR - 1));
      data_in   = DW'($urandom);
      addr_out1 = AW'($urandom_range(0, NR - 1));
      addr_out2 = ($urandom_range(0, 3) == 0) ? addr_in : AW'($urandom_range(0, NR - 1));
      #1;
      check("rand_pre_out1", data_out1, model_read(addr_out1));
      check("rand_pre_out2", data_out2, model_read(addr_out2));
      tick();
      check("rand_post_out1", data_out1, model_read(addr_out1));
      check("rand_post_out2", data_out2, model_read(addr_out2));
    end

    // Make two registers known-nonzero, then assert reset mid-cycle.
    write = 1'b1; addr_in = 5'd5; data_in = 8'h9A;
    tick();
    addr_in = 5'd6; data_in = 8'h6B;
    tick();
    write = 1'b0; addr_out1 = 5'd5; addr_out2 = 5'd6;
    #1;
    check("pre_reset_out1", data_out1, 8'h9A);
    check("pre_reset_out2", data_out2, 8'h6B);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset_out1", data_out1, 8'h00);
    check("async_reset_out2", data_out2, 8'h00);
    for (int i = 0; i < int'(NR); i++) mem[i] = '0;

    // Reset released mid-cycle; the next write edge takes effect.
    #1 reset = 1'b1;
    write = 1'b1; addr_in = 5'd5; data_in = 8'h44;
    tick();
    write = 1'b0;
    #1;
    check("post_reset_write", data_out1, 8'h44);
    check("post_reset_other", data_out2, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
